fp_align_sequencer: RTL
=======================

// Module: fp_align_sequencer
// PURPOSE
//   Multi-cycle exponent-alignment controller for the FP add/sub path. Accepts two
//   unpacked operands over a valid/ready handshake and compares their exponents.
//   It then shifts the smaller mantissa right one bit per cycle, collecting
//   guard/round/sticky bits, and presents aligned mantissas plus the common
//   exponent to the adder stage.
// PARAMETERS
//   EXP_W      8        exponent width
//   MAN_W      24       mantissa width, hidden bit included
//   MAX_SHIFT  MAN_W+2  largest difference done by iterative shifting; above it the result is flushed
// PORTS
//   clk                in   1        clock, all state updates on rising edge
//   rst                in   1        synchronous reset, active-high
//   in_valid           in   1        operand pair valid
//   in_ready           out  1        block can accept operands
//   exponent_a         in   EXP_W    exponent of operand A
//   exponent_b         in   EXP_W    exponent of operand B
//   mantissa_a         in   MAN_W    mantissa of A, hidden bit included
//   mantissa_b         in   MAN_W    mantissa of B, hidden bit included
//   out_valid          out  1        aligned result valid
//   out_ready          in   1        downstream accepts result
//   exp_out            out  EXP_W    larger exponent = common exponent
//   man_large          out  MAN_W    mantissa of the larger-exponent operand
//   man_small_aligned  out  MAN_W+2  smaller mantissa as {man,2'b00}, shifted right by difference (LSBs = guard, round)
//   sticky             out  1        OR of all bits shifted past the LSB
//   swap               out  1        1 = B had the larger exponent
//   busy               out  1        high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE. in_ready=1; out_valid, sticky, swap and busy =0; all data outputs =0.
//     Reset wins over every other event, including mid-SHIFT and an un-acked DONE.
//   FSM states: IDLE, COMPARE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
//   IDLE: when in_valid=1, latch all four operand fields and go to COMPARE. Otherwise stay.
//   COMPARE: one cycle.
//     - Equal exponents: A is treated as large, swap=0, no shift, go to DONE.
//     - exponent_a > exponent_b: swap=0. exponent_b > exponent_a: swap=1.
//     - diff = larger exponent - smaller exponent (unsigned, EXP_W bits).
//     - exp_out <= larger exponent; man_large <= its mantissa; small register <= {smaller mantissa, 2'b00}; sticky <= 0.
//     - diff > MAX_SHIFT: small register <= 0, sticky <= |smaller mantissa, go to DONE.
//     - diff == 0: go to DONE.
//     - Otherwise: load count <= diff, go to SHIFT.
//   SHIFT: each cycle small <= small>>1, sticky <= sticky | small[0], count <= count-1.
//     When count reaches 0 after the decrement, go to DONE. Exactly diff shift cycles.
//   DONE: outputs are held stable while out_ready=0. When out_ready=1, go to IDLE.
//     No new accept in that same cycle; the next operand is accepted earliest one cycle later.
//   Latency (operands accepted on cycle T): out_valid on T+2 when diff==0 or diff>MAX_SHIFT.
//     On T+2+diff for 1 <= diff <= MAX_SHIFT.
//   Handshake rules:
//     - out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored.
//     - Upstream must hold the operands only during the accept cycle.
//   Width rules: count is EXP_W bits. diff is never negative because the larger exponent is selected first.
//     Exponent value 0 needs no special case; denormal handling belongs upstream.
// TESTING
//   1 exp_a=8'h85, exp_b=8'h82, man_a=24'h800000, man_b=24'hC00000 -> swap=0, exp_out=8'h85,
//     man_small_aligned=26'h0600000, sticky=0, out_valid on T+5.
//   2 exp_a=8'h80, exp_b=8'h83, man_a=24'h800001, man_b=24'h900000 -> swap=1, exp_out=8'h83,
//     man_large=24'h900000, man_small_aligned=26'h0400000, sticky=1, out_valid on T+5.
//   3 exp_a=exp_b=8'h7F, man_b=24'hA00000 -> swap=0, man_small_aligned=26'h2800000, sticky=0, out_valid on T+2.
//   4 exp_a=8'h90, exp_b=8'h01, man_b=24'h800000 (diff 143 > 26) -> man_small_aligned=0, sticky=1, out_valid on T+2.
//   5 Backpressure: case 1 with out_ready=0 for 4 cycles after out_valid -> outputs stable, in_ready=0.
//     Then out_ready=1 -> IDLE next cycle; a second pair is accepted the cycle after.
//   6 Reset: rst=1 on cycle T+3 of case 1 (mid-SHIFT) -> next cycle IDLE, in_ready=1, out_valid=0,
//     data outputs 0. A fresh operand pair then completes correctly.

Source files
------------

// File: rtl/fp_align_sequencer_if.sv
// Operand/result bundle between the unpacked-operand source, the alignment sequencer and the adder stage.
interface fp_align_sequencer_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exponent_a;
  logic [EXP_W-1:0] exponent_b;
  logic [MAN_W-1:0] mantissa_a;
  logic [MAN_W-1:0] mantissa_b;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_out;
  logic [MAN_W-1:0] man_large;
  logic [MAN_W+1:0] man_small_aligned;
  logic             sticky;
  logic             swap;
  logic             busy;

  modport master (
    output in_valid, exponent_a, exponent_b, mantissa_a, mantissa_b, out_ready,
    input  in_ready, out_valid, exp_out, man_large, man_small_aligned, sticky, swap, busy
  );

  modport slave (
    input  in_valid, exponent_a, exponent_b, mantissa_a, mantissa_b, out_ready,
    output in_ready, out_valid, exp_out, man_large, man_small_aligned, sticky, swap, busy
  );
endinterface

// File: rtl/fp_align_sequencer.sv
// Exponent-alignment controller: picks the larger exponent, then shifts the smaller
// mantissa right one bit per cycle while accumulating guard/round/sticky.
//
// state   | meaning
// IDLE    | waiting for an operand pair, in_ready high
// COMPARE | pick larger exponent, load shift count or short-cut to DONE
// SHIFT   | one right shift of the small mantissa per cycle, count down to 1
// DONE    | result presented, held until out_ready
module fp_align_sequencer #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MAN_W     = 24,
  parameter int unsigned MAX_SHIFT = MAN_W + 2
) (
  input logic                 clk,
  input logic                 rst,
  fp_align_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [EXP_W-1:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [MAN_W-1:0] man_a_q, man_a_d, man_b_q, man_b_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] exp_out_q, exp_out_d;
  logic [MAN_W-1:0] man_large_q, man_large_d;
  logic [MAN_W+1:0] small_q, small_d;
  logic             sticky_q, sticky_d;
  logic             swap_q, swap_d;

  logic             a_big;
  logic [EXP_W-1:0] exp_hi, exp_lo, diff;
  logic [MAN_W-1:0] man_hi, man_lo;

  // Ties go to A so equal exponents never report a swap.
  always_comb begin
    a_big  = (exp_a_q >= exp_b_q);
    exp_hi = a_big ? exp_a_q : exp_b_q;
    exp_lo = a_big ? exp_b_q : exp_a_q;
    man_hi = a_big ? man_a_q : man_b_q;
    man_lo = a_big ? man_b_q : man_a_q;
    diff   = exp_hi - exp_lo;
  end

  always_comb begin
    state_d     = state_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    man_a_d     = man_a_q;
    man_b_d     = man_b_q;
    cnt_d       = cnt_q;
    exp_out_d   = exp_out_q;
    man_large_d = man_large_q;
    small_d     = small_q;
    sticky_d    = sticky_q;
    swap_d      = swap_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          exp_a_d = bus.exponent_a;
          exp_b_d = bus.exponent_b;
          man_a_d = bus.mantissa_a;
          man_b_d = bus.mantissa_b;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        swap_d      = ~a_big;
        exp_out_d   = exp_hi;
        man_large_d = man_hi;
        small_d     = {man_lo, 2'b00};
        sticky_d    = 1'b0;
        if (32'(diff) > MAX_SHIFT) begin
          // Everything would fall off the end: flush and keep only the sticky OR.
          small_d  = '0;
          sticky_d = |man_lo;
          state_d  = DONE;
        end else if (diff == '0) begin
          state_d = DONE;
        end else begin
          cnt_d   = diff;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        small_d  = small_q >> 1;
        sticky_d = sticky_q | small_q[0];
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      man_a_q     <= '0;
      man_b_q     <= '0;
      cnt_q       <= '0;
      exp_out_q   <= '0;
      man_large_q <= '0;
      small_q     <= '0;
      sticky_q    <= 1'b0;
      swap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      man_a_q     <= man_a_d;
      man_b_q     <= man_b_d;
      cnt_q       <= cnt_d;
      exp_out_q   <= exp_out_d;
      man_large_q <= man_large_d;
      small_q     <= small_d;
      sticky_q    <= sticky_d;
      swap_q      <= swap_d;
    end
  end

  assign bus.in_ready          = (state_q == IDLE);
  assign bus.out_valid         = (state_q == DONE);
  assign bus.busy              = (state_q != IDLE);
  assign bus.exp_out           = exp_out_q;
  assign bus.man_large         = man_large_q;
  assign bus.man_small_aligned = small_q;
  assign bus.sticky            = sticky_q;
  assign bus.swap              = swap_q;

endmodule
